// File: rtl/fp_div_arbiter.sv
// Two-requester round-robin front end for a fixed-latency fp_divider.
// One operation in flight; zero divisors answer with a signed infinity and bypass the divider.
module fp_div_arbiter #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_dz,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             id_reg;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] div_a_reg, div_b_reg, rsp_data_reg;
  logic             rsp_valid_reg, rsp_dz_reg;

  logic [1:0]       req_valid, req_ready;
  logic             grant, accept, sel_dz;
  logic [WIDTH-1:0] sel_a, sel_b;

  assign req_valid = {req1_valid, req0_valid};

  // On contention the requester not granted last wins; otherwise the lone requester.
  assign grant = (&req_valid) ? ~last_grant_reg : req_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign accept     = |req_ready;
  assign sel_a      = grant ? req1_a : req0_a;
  assign sel_b      = grant ? req1_b : req0_b;
  // Sign bit ignored so that both +0 and -0 are treated as a zero divisor.
  assign sel_dz     = (sel_b[WIDTH-2:0] == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = sel_dz ? RESP : WAIT;
      WAIT:    if (cnt_reg == 4'd1) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      cnt_reg        <= 4'd0;
      div_a_reg      <= '0;
      div_b_reg      <= '0;
      rsp_data_reg   <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_dz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            div_a_reg      <= sel_a;
            div_b_reg      <= sel_b;
            id_reg         <= grant;
            last_grant_reg <= grant;
            cnt_reg        <= CNT_LOAD;
            if (sel_dz) begin
              rsp_valid_reg <= 1'b1;
              rsp_dz_reg    <= 1'b1;
              rsp_data_reg  <= {sel_a[WIDTH-1] ^ sel_b[WIDTH-1], 8'hFF, {(WIDTH-9){1'b0}}};
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd1) begin
            rsp_data_reg  <= div_out;
            rsp_valid_reg <= 1'b1;
            rsp_dz_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign div_a     = div_a_reg;
  assign div_b     = div_b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = id_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_dz    = rsp_dz_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: behavioural fp_divider stand-in, transaction-level reference
// model checked every cycle, directed scenarios followed by a randomized run.
module tb_fp_div_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] div_a, div_b, div_out;
  logic        rsp_valid, rsp_id, rsp_dz, busy;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  always #5 clk = ~clk;

  fp_div_arbiter #(.LATENCY(LAT), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .div_a(div_a), .div_b(div_b), .div_out(div_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Single-precision arithmetic via double: exact for normal operands and
  // double-to-single rounding of a quotient is free of double-rounding error.
  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    int e;
    if (x[30:23] == 8'd0) return 0.0;
    e = int'(x[30:23]);
    d = {x[31], 11'(e + 896), x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [30:0] v;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    v = {8'(e), d[51:29]};
    if (d[28] && ((|d[27:0]) || v[0])) v = v + 31'd1;
    return {d[63], v};
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = a[31] ^ b[31];
    if (b[30:0] == 31'h0) return {s, 8'hFF, 23'h0};
    if (a[30:0] == 31'h0) return {s, 31'h0};
    return real2sp(sp2real(a) / sp2real(b));
  endfunction

  // fp_divider stand-in: LAT-1 register stages, so the result is ready for the LAT-th edge.
  logic [31:0] div_q;
  always @(posedge clk) div_q <= fdiv(div_a, div_b);
  assign div_out = div_q;

  // Transaction-level reference model.
  bit          m_busy, m_rv, m_last, m_id, m_dz;
  logic [31:0] m_div_a, m_div_b, m_data;
  int          m_due;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit winner();
    if (req0_valid && req1_valid) return (m_last == 1'b1) ? 1'b0 : 1'b1;
    if (req0_valid) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rv = 0; m_last = 1; m_id = 0; m_dz = 0;
    m_div_a = '0; m_div_b = '0; m_data = '0; m_due = 0;
  endtask

  task automatic model_edge();
    bit w;
    logic [31:0] a, b;
    if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        w = winner();
        a = w ? req1_a : req0_a;
        b = w ? req1_b : req0_b;
        m_last = w; m_id = w; m_div_a = a; m_div_b = b; m_busy = 1;
        n_acc++;
        $display("[%0t] accept id=%0d a=%h b=%h", $time, w, a, b);
        if (b[30:0] == 31'h0) begin
          m_rv = 1; m_dz = 1; m_data = {a[31] ^ b[31], 8'hFF, 23'h0};
        end else begin
          m_due = LAT;
        end
      end
    end else if (!m_rv) begin
      m_due--;
      if (m_due == 0) begin
        m_rv = 1; m_dz = 0; m_data = fdiv(m_div_a, m_div_b);
      end
    end else if (rsp_ready) begin
      $display("[%0t] response id=%0d data=%h dz=%0d", $time, m_id, m_data, m_dz);
      m_rv = 0; m_busy = 0;
    end
  endtask

  // Check outputs mid-cycle, then advance one edge; returns 1 time unit after the edge.
  task automatic cycle();
    bit w;
    @(negedge clk);
    w = winner();
    check("ready0", req0_ready, 32'(!m_busy && req0_valid && w == 1'b0));
    check("ready1", req1_ready, 32'(!m_busy && req1_valid && w == 1'b1));
    check("busy", busy, 32'(m_busy));
    check("rsp_valid", rsp_valid, 32'(m_rv));
    if (m_rv) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_id", rsp_id, 32'(m_id));
      check("rsp_dz", rsp_dz, 32'(m_dz));
    end
    check("div_a", div_a, m_div_a);
    check("div_b", div_b, m_div_b);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_dz", rsp_dz, 0);
    check("rst_readys", {req1_ready, req0_ready}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, rsp_valid, 1);
  endtask

  function automatic logic [31:0] rand_op(input bit allow_zero);
    logic s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    if (allow_zero && $urandom_range(0, 7) == 0) return {s, 31'h0};
    e = 8'($urandom_range(100, 154));
    m = 23'($urandom);
    return {s, e, m};
  endfunction

  initial begin
    model_reset();
    apply_reset();

    // 20/2 on req0: response exactly LAT edges after accept.
    req0_valid = 1; req0_a = 32'h41A00000; req0_b = 32'h40000000; rsp_ready = 1;
    cycle();
    req0_valid = 0;
    check("s1_edge0_valid", rsp_valid, 0);
    check("s1_busy", busy, 1);
    cycle();
    check("s1_edge1_valid", rsp_valid, 0);
    cycle();
    check("s1_edge2_valid", rsp_valid, 1);
    check("s1_data", rsp_data, 32'h41200000);
    check("s1_id", rsp_id, 0);
    check("s1_dz", rsp_dz, 0);
    cycle();
    check("s1_idle", busy, 0);

    // Simultaneous requests after reset: req0 first, then req1.
    apply_reset();
    req0_valid = 1; req0_a = 32'h41A00000; req0_b = 32'h42C80000;
    req1_valid = 1; req1_a = 32'h41900000; req1_b = 32'h40400000;
    cycle();
    req0_valid = 0;
    wait_rsp("s2a");
    check("s2a_data", rsp_data, 32'h3E4CCCCD);
    check("s2a_id", rsp_id, 0);
    cycle();
    cycle();
    req1_valid = 0;
    wait_rsp("s2b");
    check("s2b_data", rsp_data, 32'h40C00000);
    check("s2b_id", rsp_id, 1);
    cycle();

    // Both held valid: grants alternate starting with requester 0.
    apply_reset();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req0_a = rand_op(0); req0_b = rand_op(0);
      req1_a = rand_op(0); req1_b = rand_op(0);
      wait_rsp("s3");
      check("s3_alt_id", rsp_id, 32'(i % 2));
      cycle();
    end
    req0_valid = 0; req1_valid = 0;
    cycle();

    // 5 / -0 on req1: RESP on the accept edge with negative infinity.
    apply_reset();
    req1_valid = 1; req1_a = 32'h40A00000; req1_b = 32'h80000000;
    cycle();
    req1_valid = 0;
    check("s4_valid", rsp_valid, 1);
    check("s4_dz", rsp_dz, 1);
    check("s4_data", rsp_data, 32'hFF800000);
    check("s4_id", rsp_id, 1);
    cycle();
    check("s4_idle", busy, 0);

    // Backpressure: 20/6 held stable while rsp_ready is low.
    req0_valid = 1; req0_a = 32'h41A00000; req0_b = 32'h40C00000; rsp_ready = 0;
    cycle();
    req0_valid = 0;
    wait_rsp("s5");
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s5_hold_data", rsp_data, 32'h40555555);
      check("s5_hold_valid", rsp_valid, 1);
      check("s5_hold_readys", {req1_ready, req0_ready}, 0);
      check("s5_hold_busy", busy, 1);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    cycle();
    check("s5_release_idle", busy, 0);
    check("s5_release_valid", rsp_valid, 0);

    // Reset mid-WAIT aborts; then a fresh 20/2 on req1.
    req0_valid = 1; req0_a = 32'h41A00000; req0_b = 32'h40000000;
    cycle();
    req0_valid = 0;
    check("s6_in_wait", busy, 1);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s6_no_rsp", rsp_valid, 0);
    end
    req1_valid = 1; req1_a = 32'h41A00000; req1_b = 32'h40000000;
    cycle();
    req1_valid = 0;
    wait_rsp("s6");
    check("s6_data", rsp_data, 32'h41200000);
    check("s6_id", rsp_id, 1);
    cycle();

    // Randomized traffic against the model.
    n_acc = 0;
    for (int i = 0; i < 600; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = rand_op(0); req0_b = rand_op(1);
      req1_a = rand_op(0); req1_b = rand_op(1);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (LAT + 3) cycle();
    check("rand_activity", 32'(n_acc > 20), 1);
    check("rand_drained", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: clock edges from a div_a/div_b change to a valid div_out; legal range 1..15.
REQ-002 Parameter WIDTH, default 32: IEEE-754 single-precision operand and result width.
REQ-003 clk  input  1  rising-edge clock; the block's only clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 has an operand pair to issue.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 dividend and divisor.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready: same as REQ-005..007, for requester 1.
REQ-009 div_a, div_b  output  WIDTH  registered operands to the fp_divider a_fpn/b_fpn.
REQ-010 div_out  input  WIDTH  fp_divider result.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_id  output  1  requester that owns the result.
REQ-013 rsp_data  output  WIDTH  quotient.
REQ-014 rsp_dz  output  1  divisor was zero.
REQ-015 rsp_ready  input  1  consumer accepts the result.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The block SHALL use a three-state FSM: IDLE, WAIT, RESP. At most one operation is outstanding at any time.
REQ-018 In IDLE, the block SHALL assert at most one reqN_ready, combinationally, and only for the arbitration winner. Both ready outputs SHALL be 0 in WAIT and RESP.
REQ-019 Arbitration SHALL be round-robin:
- single valid: that requester wins;
- both valid: the requester not granted last wins;
- after reset, requester 0 has priority.
REQ-020 An operand pair transfers on reqN_valid & reqN_ready at a rising edge (the accept edge). At that edge the block SHALL:
- latch a/b into div_a/div_b;
- latch N into the id register;
- load the down-counter with LATENCY;
- set last_grant to N.
REQ-021 div_a and div_b SHALL hold their value from the accept edge until the next accept edge.
REQ-022 Divisor zero means b[30:0] == 0, so both +0 and -0 count as zero. On a zero divisor the block SHALL, at the accept edge:
- go directly to RESP;
- set rsp_valid=1, rsp_dz=1;
- set rsp_data = {a[31]^b[31], 8'hFF, 23'h0} (signed infinity).
REQ-023 On a nonzero divisor the block SHALL go to WAIT.
REQ-024 In WAIT, at each rising edge:
- if counter==1, capture div_out into rsp_data, set rsp_valid=1 and rsp_dz=0, and go to RESP;
- otherwise decrement the counter.
REQ-025 Consequently, rsp_valid SHALL rise exactly LATENCY edges after the accept edge.
REQ-026 rsp_id SHALL equal the latched id whenever rsp_valid=1.
REQ-027 In RESP, rsp_valid, rsp_data, rsp_id and rsp_dz SHALL hold stable until rsp_valid & rsp_ready at an edge. At that edge the block SHALL clear rsp_valid and go to IDLE.
REQ-028 A new accept SHALL NOT occur in the same edge as a response handshake. The earliest next accept is the edge after the return to IDLE.
REQ-029 If reqN_valid drops while reqN_ready=0, the block SHALL take no action; there is no request retention.
REQ-030 The counter SHALL be 4 bits wide and SHALL never wrap; it is used only in WAIT.

Reset
REQ-031 When rst=0, the block SHALL asynchronously:
- set state=IDLE and last_grant=1, so requester 0 has priority;
- set counter=0 and id=0;
- set div_a=0, div_b=0, rsp_data=0;
- set rsp_valid=0, rsp_dz=0, rsp_id=0.
REQ-032 Reset asserted in WAIT or RESP SHALL abort the operation; no rsp_valid SHALL be produced for it after release.
REQ-033 The first accept is possible at the first rising edge after rst returns to 1.

Verification
REQ-034 The bench SHALL pair this block with fp_divider and run LATENCY=2 unless stated otherwise. It SHALL cover these directed scenarios:
- req0 0x41A00000 / 0x40000000 (20/2), rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_data=0x41200000, rsp_id=0, rsp_dz=0.
- req0 20/100 and req1 18/3 both valid in the same IDLE cycle after reset -> req0 served first (0x3E4CCCCD); then req1 (0x40C00000, id=1).
- Both requesters held valid continuously -> grants alternate 0,1,0,1; no requester is starved.
- req1 0x40A00000 / 0x80000000 (5/-0) -> next edge: RESP, rsp_dz=1, rsp_data=0xFF800000, no WAIT cycles.
- rsp_ready held 0 for 5 cycles after 20/6 -> rsp_data=0x40555555 stable, both readys 0, busy=1; on release, IDLE one edge later.
- rst=0 pulsed in mid-WAIT -> all outputs 0 immediately; no response after release; a fresh 20/2 on req1 completes with rsp_data=0x41200000.
